tmr_scrub_ram: RTL
==================

Name: tmr_scrub_ram

Overview:
- Triple-modular-redundant register file: `2**aw` words of `dw` bits, each word stored in three copies.
- Read data is bitwise majority-voted.
- A background scrubber walks all addresses and rewrites the voted value into every copy when the copies disagree.
- Provides fault injection, correction reporting and a saturating correction counter, for SEU-hardened configuration/state storage.

Parameters:
- dw, 8, data width in bits
- aw, 3, address width; depth = 2**aw
- sdiv, 16, idle cycles between scrub checks (>=1)
- cw, 16, width of correction counter

Ports:
- c  input  1  clock, all state on rising edge
- r  input  1  reset, asynchronous, active-high
- we  input  1  write enable
- wa  input  aw  write address
- d  input  dw  write data
- ra  input  aw  read address
- q  output  dw  registered voted read data
- rerr  output  1  registered: copies of word ra disagree
- scrub_en  input  1  enable background scrubber
- inj  input  1  fault-injection strobe
- inj_sel  input  2  copy to corrupt (0..2; 3 = no effect)
- inj_a  input  aw  injection address
- inj_m  input  dw  XOR mask applied to selected copy
- cnt_clr  input  1  synchronous clear of fix_cnt
- fix_v  output  1  one-cycle pulse: a correction was written
- fix_a  output  aw  address of last correction
- fix_cnt  output  cw  saturating correction count

Behaviour:
- Reset (r high, asynchronous): all three copies of every word = 0; q=0, rerr=0, fix_v=0, fix_a=0, fix_cnt=0; scrub pointer sa=0; divider=0; FSM=IDLE. Reset takes effect immediately, including mid-FIX.
- Vote: `v = (m0&m1)|(m0&m2)|(m1&m2)`; mismatch = `|((m0^m1)|(m0^m2))`.
- Read: each edge, q <= vote(ra) and rerr <= mismatch(ra), using pre-edge contents. Latency is 1 cycle. Read-during-write returns old data.
- Write: if we, all three copies at wa <= d.
- Injection: if inj and inj_sel<3, the selected copy at inj_a <= (post-write value) ^ inj_m. Injection is applied on top of a same-cycle write to the same address.
- Priority per word: reset > user write > scrub fix; injection XOR is applied last.
- FSM states:
  - IDLE: divider counts while scrub_en. When divider==sdiv-1 -> CHECK, divider <= 0.
  - CHECK: evaluate mismatch(sa). If mismatch -> FIX. Otherwise sa <= sa+1 (wraps 2**aw-1 -> 0) and -> IDLE.
  - FIX: re-evaluate mismatch(sa) this cycle.
    - If still mismatched and not (we && wa==sa): all copies at sa <= vote(sa); fix_v <= 1; fix_a <= sa; fix_cnt increments.
    - Otherwise no write and no count.
    - In both cases sa <= sa+1 and -> IDLE.
- scrub_en low: FSM -> IDLE at next edge; divider cleared; sa held. A FIX in progress completes only if scrub_en is still high in the FIX cycle.
- fix_v is high for exactly one cycle per correction; otherwise 0.
- fix_cnt saturates at 2**cw-1. cnt_clr forces 0 and wins over a same-cycle increment.

Test Plan:
- Reset; write 0xA5 @2; ra=2 -> q=0xA5 one cycle later, rerr=0; other addresses read 0x00.
- Inject copy1 @2 mask 0x0F -> q=0xA5, rerr=1. With scrub_en=1, within 8*(sdiv+2) cycles: fix_v pulses once with fix_a=2, fix_cnt=1; afterwards rerr=0 at ra=2.
- Inject mask 0x01 into copy0 and copy1 @2 (holding 0xA5) -> q=0xA4; scrub rewrites 0xA4 to all copies; fix_cnt increments; rerr then 0.
- Corrupt @sa, then write 0x3C to wa=sa during the FIX cycle -> all copies 0x3C, no fix_v, fix_cnt unchanged, sa advances.
- With cw=2: 4 corrections give fix_cnt=3 (held). cnt_clr coincident with a correction -> fix_cnt=0, fix_v still pulses.
- Assert r during FIX -> q, rerr, fix_v, fix_a, fix_cnt read 0 before the next edge; all words read 0x00 with rerr=0; scrubber restarts from sa=0.

Source files
------------

// File: rtl/tmr_scrub_ram.sv
// Triple-modular-redundant register file with majority-voted reads, a background
// scrubber that rewrites disagreeing words, fault injection and correction reporting.
module tmr_scrub_ram #(
   parameter int unsigned dw   = 8,
   parameter int unsigned aw   = 3,
   parameter int unsigned sdiv = 16,
   parameter int unsigned cw   = 16
) (
   input  logic          c,
   input  logic          r,
   input  logic          we,
   input  logic [aw-1:0] wa,
   input  logic [dw-1:0] d,
   input  logic [aw-1:0] ra,
   output logic [dw-1:0] q,
   output logic          rerr,
   input  logic          scrub_en,
   input  logic          inj,
   input  logic [1:0]    inj_sel,
   input  logic [aw-1:0] inj_a,
   input  logic [dw-1:0] inj_m,
   input  logic          cnt_clr,
   output logic          fix_v,
   output logic [aw-1:0] fix_a,
   output logic [cw-1:0] fix_cnt
);
   localparam int unsigned depth = 2 ** aw;
   localparam int unsigned dvw   = (sdiv > 1) ? $clog2(sdiv) : 1;

   typedef enum logic [1:0] {IDLE, CHECK, FIX} st_t;

   logic [dw-1:0]  m0 [depth];
   logic [dw-1:0]  m1 [depth];
   logic [dw-1:0]  m2 [depth];
   logic [dw-1:0]  n0 [depth];
   logic [dw-1:0]  n1 [depth];
   logic [dw-1:0]  n2 [depth];
   st_t            st, st_n;
   logic [aw-1:0]  sa, sa_n;
   logic [dvw-1:0] dv, dv_n;
   logic           fix_go;
   logic [dw-1:0]  s_vote;
   logic           s_mism;

   function automatic logic [dw-1:0] vote(input logic [dw-1:0] a, input logic [dw-1:0] b,
                                          input logic [dw-1:0] e);
      return (a & b) | (a & e) | (b & e);
   endfunction

   function automatic logic mism(input logic [dw-1:0] a, input logic [dw-1:0] b,
                                 input logic [dw-1:0] e);
      return |((a ^ b) | (a ^ e));
   endfunction

   assign s_vote = vote(m0[sa], m1[sa], m2[sa]);
   assign s_mism = mism(m0[sa], m1[sa], m2[sa]);

   // Scrub sequencer: divider in IDLE, one address per CHECK, optional FIX
   always_comb begin
      st_n   = st;
      sa_n   = sa;
      dv_n   = dv;
      fix_go = 1'b0;
      if (!scrub_en) begin
         st_n = IDLE;
         dv_n = '0;
      end else begin
         case (st)
            IDLE: begin
               if (dv == dvw'(sdiv - 1)) begin
                  st_n = CHECK;
                  dv_n = '0;
               end else begin
                  dv_n = dv + dvw'(1);
               end
            end
            CHECK: begin
               if (s_mism) begin
                  st_n = FIX;
               end else begin
                  sa_n = sa + aw'(1);
                  st_n = IDLE;
               end
            end
            FIX: begin
               // A user write to the same word supersedes the correction
               fix_go = s_mism && !(we && (wa == sa));
               sa_n   = sa + aw'(1);
               st_n   = IDLE;
            end
            default: st_n = IDLE;
         endcase
      end
   end

   // Per-word next value: write beats fix, injection XOR lands on top
   always_comb begin
      for (int i = 0; i < int'(depth); i++) begin
         n0[i] = m0[i];
         n1[i] = m1[i];
         n2[i] = m2[i];
         if (we && (wa == aw'(i))) begin
            n0[i] = d;
            n1[i] = d;
            n2[i] = d;
         end else if (fix_go && (sa == aw'(i))) begin
            n0[i] = s_vote;
            n1[i] = s_vote;
            n2[i] = s_vote;
         end
         if (inj && (inj_a == aw'(i))) begin
            case (inj_sel)
               2'd0:    n0[i] = n0[i] ^ inj_m;
               2'd1:    n1[i] = n1[i] ^ inj_m;
               2'd2:    n2[i] = n2[i] ^ inj_m;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge c or posedge r) begin
      if (r) begin
         for (int i = 0; i < int'(depth); i++) begin
            m0[i] <= '0;
            m1[i] <= '0;
            m2[i] <= '0;
         end
         st      <= IDLE;
         sa      <= '0;
         dv      <= '0;
         q       <= '0;
         rerr    <= 1'b0;
         fix_v   <= 1'b0;
         fix_a   <= '0;
         fix_cnt <= '0;
      end else begin
         for (int i = 0; i < int'(depth); i++) begin
            m0[i] <= n0[i];
            m1[i] <= n1[i];
            m2[i] <= n2[i];
         end
         st    <= st_n;
         sa    <= sa_n;
         dv    <= dv_n;
         q     <= vote(m0[ra], m1[ra], m2[ra]);
         rerr  <= mism(m0[ra], m1[ra], m2[ra]);
         fix_v <= fix_go;
         if (fix_go) begin
            fix_a <= sa;
         end
         if (cnt_clr) begin
            fix_cnt <= '0;
         end else if (fix_go && (fix_cnt != {cw{1'b1}})) begin
            fix_cnt <= fix_cnt + cw'(1);
         end
      end
   end
endmodule
